// File: rtl/pred_pmu_window_ctrl.sv
// pred_pmu_window_ctrl: windowed branch-prediction sampler with snapshot valid/ready readout
module pred_pmu_window_ctrl #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 16,
  parameter int ID_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             EX_feedback_valid,
  input  logic             EX_prediction_incorrect,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [CNT_W-1:0] snap_total,
  output logic [CNT_W-1:0] snap_wrong,
  output logic [ID_W-1:0]  snap_id,
  output logic             snap_partial,
  output logic             snap_overrun,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  state_e state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] total_q, total_d, wrong_q, wrong_d, tot_n, wr_n, ld_total, ld_wrong;
  logic [CNT_W-1:0] snap_total_q, snap_wrong_q;
  logic [ID_W-1:0]  id_q, id_d, snap_id_q;
  logic             snap_valid_q, snap_partial_q, ovr_q, ovr_d;
  logic             done, can_load, load, ld_partial;
  always_comb begin
    tot_n      = total_q + CNT_W'(EX_feedback_valid);
    wr_n       = wrong_q + CNT_W'(EX_feedback_valid & EX_prediction_incorrect);
    done       = EX_feedback_valid && tot_n == CNT_W'(win_q);
    can_load   = !snap_valid_q || snap_ready;
    state_d    = state_q;
    win_d      = win_q;
    total_d    = total_q;
    wrong_d    = wrong_q;
    ovr_d      = ovr_q;
    id_d       = id_q;
    load       = 1'b0;
    ld_total   = total_q;
    ld_wrong   = wrong_q;
    ld_partial = 1'b0;
    case (state_q)
      IDLE: if (cfg_start && cfg_window != '0) begin
        state_d = RUN;
        win_d   = cfg_window;
        total_d = '0;
        wrong_d = '0;
        ovr_d   = 1'b0;
        id_d    = '0;
      end
      RUN: begin
        // a completing event clears the counters whether or not its snapshot is kept
        total_d = done ? '0 : tot_n;
        wrong_d = done ? '0 : wr_n;
        if (done) begin
          ld_total = tot_n;
          ld_wrong = wr_n;
          load     = can_load;
          ovr_d    = ovr_q | !can_load;
        end
        if (cfg_stop) state_d = (done || tot_n == '0) ? IDLE : FLUSH;
      end
      FLUSH: if (can_load) begin
        load       = 1'b1;
        ld_partial = 1'b1;
        total_d    = '0;
        wrong_d    = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) id_d = id_q + ID_W'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      win_q          <= '0;
      total_q        <= '0;
      wrong_q        <= '0;
      ovr_q          <= 1'b0;
      id_q           <= '0;
      snap_valid_q   <= 1'b0;
      snap_total_q   <= '0;
      snap_wrong_q   <= '0;
      snap_id_q      <= '0;
      snap_partial_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      total_q <= total_d;
      wrong_q <= wrong_d;
      ovr_q   <= ovr_d;
      id_q    <= id_d;
      if (load) begin
        snap_valid_q   <= 1'b1;
        snap_total_q   <= ld_total;
        snap_wrong_q   <= ld_wrong;
        snap_id_q      <= id_q;
        snap_partial_q <= ld_partial;
      end else if (snap_ready) begin
        snap_valid_q <= 1'b0;
      end
    end
  end
  assign snap_valid   = snap_valid_q;
  assign snap_total   = snap_total_q;
  assign snap_wrong   = snap_wrong_q;
  assign snap_id      = snap_id_q;
  assign snap_partial = snap_partial_q;
  assign snap_overrun = ovr_q;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_pred_pmu_window_ctrl.sv
// tb_pred_pmu_window_ctrl: scoreboard bench for the windowed prediction sampler
module tb_pred_pmu_window_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, cfg_start, cfg_stop, fb_v, fb_w, snap_ready;
  logic [15:0] cfg_window;
  logic        snap_valid, snap_partial, snap_overrun, busy;
  logic [31:0] snap_total, snap_wrong;
  logic [7:0]  snap_id;
  typedef struct packed {logic [31:0] t; logic [31:0] w; logic [7:0] id; logic p;} snap_t;
  snap_t sbq[$];
  snap_t e;
  int total = 0, bad = 0;
  pred_pmu_window_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_window(cfg_window), .EX_feedback_valid(fb_v), .EX_prediction_incorrect(fb_w),
    .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_total(snap_total),
    .snap_wrong(snap_wrong), .snap_id(snap_id), .snap_partial(snap_partial),
    .snap_overrun(snap_overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [15:0] w);
    cfg_window = w;
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
  endtask
  task automatic stop_idle();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rst_n && snap_valid && snap_ready) begin
      if (sbq.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("snap_total", snap_total, e.t);
        chk("snap_wrong", snap_wrong, e.w);
        chk("snap_id", snap_id, e.id);
        chk("snap_partial", snap_partial, e.p);
      end
    end
  end
  initial begin
    rst_n = 1'b0; cfg_start = 0; cfg_stop = 0; cfg_window = 0; fb_v = 0; fb_w = 0; snap_ready = 0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_valid", snap_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", snap_overrun, 0);
    chk("rst_total", snap_total, 0);
    chk("rst_id", snap_id, 0);
    chk("rst_partial", snap_partial, 0);
    // T1: window 4, 2nd and 4th wrong
    snap_ready = 1'b1;
    start(16'd4);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      fb_v = 1'b1; fb_w = (i % 2 == 1);
      if (i == 3) sbq.push_back('{32'd4, 32'd2, 8'd0, 1'b0});
      tick();
      if (i == 2) chk("t1_early_valid", snap_valid, 0);
    end
    fb_v = 0; fb_w = 0;
    chk("t1_valid", snap_valid, 1);
    tick();
    chk("t1_valid_drop", snap_valid, 0);
    stop_idle();
    chk("t1_idle", busy, 0);
    // T2: back-to-back windows of 3 with ready held
    start(16'd3);
    for (int i = 0; i < 9; i++) begin
      fb_v = 1'b1; fb_w = (i % 3 == 0);
      if (i % 3 == 2) sbq.push_back('{32'd3, 32'd1, 8'(i / 3), 1'b0});
      tick();
    end
    fb_v = 0; fb_w = 0;
    tick();
    chk("t2_drained", sbq.size(), 0);
    stop_idle();
    chk("t2_idle", busy, 0);
    // T3: window 2, consumer stalled, second window dropped
    snap_ready = 1'b0;
    start(16'd2);
    for (int i = 0; i < 4; i++) begin
      fb_v = 1'b1; fb_w = 1'b0;
      if (i == 1) sbq.push_back('{32'd2, 32'd0, 8'd0, 1'b0});
      tick();
    end
    fb_v = 0;
    chk("t3_overrun", snap_overrun, 1);
    chk("t3_valid", snap_valid, 1);
    chk("t3_hold_id", snap_id, 0);
    chk("t3_hold_total", snap_total, 2);
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    chk("t3_valid_drop", snap_valid, 0);
    stop_idle();
    // T4: partial flush
    start(16'd10);
    chk("t4_overrun_clr", snap_overrun, 0);
    for (int i = 0; i < 3; i++) begin
      fb_v = 1'b1; fb_w = (i == 0);
      tick();
    end
    fb_v = 0; fb_w = 0;
    sbq.push_back('{32'd3, 32'd1, 8'd0, 1'b1});
    stop_idle();
    chk("t4_flush_busy", busy, 1);
    chk("t4_flush_valid", snap_valid, 0);
    tick();
    chk("t4_busy_done", busy, 0);
    chk("t4_valid", snap_valid, 1);
    chk("t4_partial", snap_partial, 1);
    snap_ready = 1'b1;
    tick();
    chk("t4_valid_drop", snap_valid, 0);
    // T5: stop coincides with completing event
    start(16'd2);
    fb_v = 1'b1; fb_w = 1'b0;
    tick();
    fb_w = 1'b1; cfg_stop = 1'b1;
    sbq.push_back('{32'd2, 32'd1, 8'd0, 1'b0});
    tick();
    fb_v = 0; fb_w = 0; cfg_stop = 0;
    chk("t5_idle", busy, 0);
    chk("t5_valid", snap_valid, 1);
    tick();
    // T6: reset with pending snapshot, then zero window start ignored
    snap_ready = 1'b0;
    start(16'd2);
    fb_v = 1'b1;
    tick(); tick();
    fb_v = 0;
    chk("t6_pending", snap_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("t6_valid", snap_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_total", snap_total, 0);
    chk("t6_id", snap_id, 0);
    rst_n = 1'b1;
    start(16'd0);
    chk("t6_zero_win", busy, 0);
    fb_v = 1'b1;
    tick(); tick();
    fb_v = 0;
    chk("t6_idle_events", snap_valid, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
